// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART TX (and future RX)
//                blocks: FSM state encoding and 8N1 frame constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4,
    ST_MARK  = 3'd5
  } uart_tx_state_e;

  localparam int   UART_DATA_BITS      = 8;
  localparam int   UART_BREAK_MIN_BITS = 11;
  localparam logic UART_IDLE_LEVEL     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock FIFO with occupancy level, full and empty flags.
//                Head entry is presented combinationally on pop_data_o.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  // Requests against a full/empty FIFO are silently ignored.
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and level bookkeeping; simultaneous push and pop keep the level.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : 8N1 UART transmitter with a byte FIFO, programmable bit
//                period (baud_div_i+1 clocks) and line BREAK generation.
//                txd_o is driven from a register so the pad never glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             wr_valid_i,
  input  logic [7:0]       wr_data_i,
  output logic             wr_ready_o,
  input  logic             break_i,
  output logic             txd_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             tx_done_o
);

  localparam logic [2:0] LAST_DATA_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [3:0] LAST_BREAK_BIT = 4'(UART_BREAK_MIN_BITS - 1);

  uart_tx_state_e   state_q;
  logic [DIV_W-1:0] div_q;      // divisor latched at frame/break start
  logic [DIV_W-1:0] cnt_q;      // bit-period down-counter
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [3:0]       brk_cnt_q;  // completed break bits, saturates at min-1
  logic             txd_q;
  logic             tx_done_q;

  logic             bit_tick;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  assign bit_tick = (cnt_q == '0);
  // A byte leaves the FIFO only when a new frame starts; break wins over data.
  assign fifo_pop = !fifo_empty && !break_i &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick));

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (wr_valid_i),
    .push_data_i (wr_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .level_o     (fifo_level_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign wr_ready_o = !fifo_full;
  assign busy_o     = (state_q != ST_IDLE) || !fifo_empty;
  assign txd_o      = txd_q;
  assign tx_done_o  = tx_done_q;

  // Frame FSM with bit timer; txd is set on the same edge the state changes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      brk_cnt_q <= '0;
      txd_q     <= UART_IDLE_LEVEL;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if ((state_q != ST_IDLE) && !bit_tick) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (break_i) begin
            state_q   <= ST_BREAK;
            txd_q     <= 1'b0;
            div_q     <= baud_div_i;
            cnt_q     <= baud_div_i;
            brk_cnt_q <= '0;
          end else if (!fifo_empty) begin
            state_q <= ST_START;
            txd_q   <= 1'b0;
            shift_q <= fifo_head;
            div_q   <= baud_div_i;
            cnt_q   <= baud_div_i;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state_q   <= ST_DATA;
            txd_q     <= shift_q[0];
            bit_cnt_q <= '0;
            cnt_q     <= div_q;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cnt_q   <= div_q;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt_q == LAST_DATA_BIT) begin
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            tx_done_q <= 1'b1;
            if (break_i) begin
              state_q   <= ST_BREAK;
              txd_q     <= 1'b0;
              div_q     <= baud_div_i;
              cnt_q     <= baud_div_i;
              brk_cnt_q <= '0;
            end else if (!fifo_empty) begin
              // Back-to-back frame: start bit follows stop bit directly.
              state_q <= ST_START;
              txd_q   <= 1'b0;
              shift_q <= fifo_head;
              div_q   <= baud_div_i;
              cnt_q   <= baud_div_i;
            end else begin
              state_q <= ST_IDLE;
              txd_q   <= UART_IDLE_LEVEL;
            end
          end
        end
        ST_BREAK: begin
          if (bit_tick) begin
            cnt_q <= div_q;
            if (brk_cnt_q != LAST_BREAK_BIT) begin
              brk_cnt_q <= brk_cnt_q + 4'd1;
            end else if (!break_i) begin
              state_q <= ST_MARK;
              txd_q   <= 1'b1;
            end
          end
        end
        ST_MARK: begin
          if (bit_tick) begin
            state_q <= ST_IDLE;
            txd_q   <= UART_IDLE_LEVEL;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
